// File: rtl/pht_ctrl_pkg.sv
// Shared sizing and types for the PHT front-end controller.
// The in-flight entry carries what a resolve needs to train the PHT and repair the GHR.
package pht_ctrl_pkg;

  localparam int IDX_W = 8;
  localparam int GHR_W = 8;
  localparam int DEPTH = 4;
  localparam int TAG_W = $clog2(DEPTH);

  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [GHR_W-1:0] ghr_snapshot;
    logic             predicted;
  } inflight_t;

  typedef enum logic {
    WIN_LKP = 1'b0,
    WIN_UPD = 1'b1
  } win_e;

endpackage

// File: rtl/pht_controller_queue.sv
// Circular in-flight branch queue: push at the tail, pop at the head, and
// clear, which drops everything still queued (the head may pop in the same cycle).
module branch_inflight_queue
  import pht_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  inflight_t        push_data,
  output inflight_t        head,
  output logic [TAG_W-1:0] wr_ptr,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty
);

  inflight_t        mem [DEPTH];
  logic [TAG_W-1:0] rd_ptr;
  logic [TAG_W-1:0] rd_ptr_nxt;

  assign rd_ptr_nxt = pop ? rd_ptr + TAG_ONE : rd_ptr;
  assign head       = mem[rd_ptr];
  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (clear) begin
        wr_ptr <= rd_ptr_nxt;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + TAG_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is pure data; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pht_controller.sv
// gshare front end: forms lookup indices, tracks in-flight branches, repairs
// the GHR on mispredicts and shares the single PHT slot between lookups and updates.
module pht_controller
  import pht_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [IDX_W-1:0] fetch_pc,
  output logic             fetch_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [TAG_W-1:0] pred_tag,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             resolve_ready,
  output logic             flush,
  output logic [IDX_W-1:0] pht_addr,
  output logic             pht_request,
  output logic             pht_result,
  output logic             pht_taken,
  input  logic             pht_prediction
);

  logic [GHR_W-1:0] ghr;
  logic             upd_pending;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  win_e             last_win;

  inflight_t        head;
  inflight_t        push_data;
  logic [TAG_W-1:0] wr_ptr;
  logic [TAG_W:0]   count;
  logic             full;
  logic             empty;

  logic [IDX_W-1:0] lkp_idx;
  logic             lkp_req;
  logic             contended;
  logic             lkp_grant;
  logic             upd_grant;
  logic             lkp_fire;
  logic             resolve_fire;
  logic             mispredict_now;

  logic             vld_p1;
  logic             pred_taken_p1;
  logic [TAG_W-1:0] pred_tag_p1;
  logic             flush_p1;

  assign lkp_idx   = fetch_pc ^ ghr;
  assign push_data = '{index: lkp_idx, ghr_snapshot: ghr, predicted: pht_prediction};

  // A lookup only competes for the slot when the queue can take it; mispredict
  // is left out here so the grant never depends on the resolve handshake.
  assign lkp_req   = fetch_valid && !full;
  assign contended = lkp_req && upd_pending;
  assign lkp_grant = !upd_pending || (last_win == WIN_UPD);
  assign upd_grant = upd_pending && (!lkp_req || (last_win == WIN_LKP));

  assign fetch_ready    = !full && lkp_grant && !mispredict_now;
  assign lkp_fire       = fetch_valid && fetch_ready;
  assign resolve_ready  = !empty && (!upd_pending || upd_grant);
  assign resolve_fire   = resolve_valid && resolve_ready;
  assign mispredict_now = resolve_fire && (resolve_taken != head.predicted);

  branch_inflight_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lkp_fire),
    .pop       (resolve_fire),
    .clear     (mispredict_now),
    .push_data (push_data),
    .head      (head),
    .wr_ptr    (wr_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    pht_addr    = '0;
    pht_request = 1'b0;
    pht_result  = 1'b0;
    pht_taken   = 1'b0;
    if (lkp_fire) begin
      pht_addr    = lkp_idx;
      pht_request = 1'b1;
    end else if (upd_grant) begin
      pht_addr    = upd_idx;
      pht_result  = 1'b1;
      pht_taken   = upd_taken;
    end
  end

  // Stage p0 -> p1: control state and registered prediction/flush outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr           <= '0;
      upd_pending   <= 1'b0;
      last_win      <= WIN_UPD;
      vld_p1        <= 1'b0;
      pred_taken_p1 <= 1'b0;
      pred_tag_p1   <= '0;
      flush_p1      <= 1'b0;
    end else begin
      if (mispredict_now)
        ghr <= {head.ghr_snapshot[GHR_W-2:0], resolve_taken};
      else if (lkp_fire)
        ghr <= {ghr[GHR_W-2:0], pht_prediction};

      if (resolve_fire)   upd_pending <= 1'b1;
      else if (upd_grant) upd_pending <= 1'b0;

      if (contended) last_win <= (last_win == WIN_UPD) ? WIN_LKP : WIN_UPD;

      vld_p1 <= lkp_fire;
      if (lkp_fire) begin
        pred_taken_p1 <= pht_prediction;
        pred_tag_p1   <= wr_ptr;
      end
      flush_p1 <= mispredict_now;
    end
  end

  always_ff @(posedge clk) begin
    if (resolve_fire) begin
      upd_idx   <= head.index;
      upd_taken <= resolve_taken;
    end
  end

  assign pred_valid = vld_p1;
  assign pred_taken = pred_taken_p1;
  assign pred_tag   = pred_tag_p1;
  assign flush      = flush_p1;

endmodule
